// File: rtl/stc_pkg.sv
// Shared types for the STC threshold detector: data widths, the detection
// record layout and the detector state encoding.
package stc_pkg;

    localparam int VID_W = 12;
    localparam int BIN_W = 12;
    localparam int LEN_W = 12;

    // One detection record as handed to plot extraction.
    typedef struct packed {
        logic [BIN_W-1:0] range;
        logic [LEN_W-1:0] len;
        logic [VID_W-1:0] peak;
    } det_rec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RUN    = 2'd2
    } det_state_t;

    // Run length counter that sticks at its all-ones value.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == {LEN_W{1'b1}}) ? v : v + {{(LEN_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/det_fifo.sv
// Record FIFO with first-word fall-through: the head entry is always on
// head_rec while empty is low. A push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module det_fifo
    import stc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  det_rec_t push_rec,
    input  logic     pop,
    output det_rec_t head_rec,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    det_rec_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           wr_en;
    logic           rd_en;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign wr_en    = push && (!full || pop);
    assign rd_en    = pop && !empty;
    assign head_rec = mem[rd_ptr_reg];

    // Storage, pointers and occupancy; everything clears so a reset flushes
    // all buffered records.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr_reg] <= push_rec;
                wr_ptr_reg      <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/stc_detector.sv
// Threshold detector on the STC-corrected video path. Groups consecutive
// samples with vid_in >= thr into runs and emits {range, len, peak} records
// over a valid/ready handshake. Build option DET_FIFO_EN selects a FIFO of
// FIFO_DEPTH records; without it a single output register holds one record.
module stc_detector
    import stc_pkg::*;
#(
    parameter int MIN_LEN    = 3,
    parameter int MAX_BIN    = 4095,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [VID_W-1:0] vid_in,
    input  logic [VID_W-1:0] thr,
    output logic             det_valid,
    input  logic             det_ready,
    output logic [BIN_W-1:0] det_range,
    output logic [LEN_W-1:0] det_len,
    output logic [VID_W-1:0] det_peak,
    output logic             det_drop
);

    det_state_t       state_reg, state_next;
    logic [BIN_W-1:0] bin_reg, bin_next;
    logic [BIN_W-1:0] start_reg, start_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [VID_W-1:0] peak_reg, peak_next;
    logic             drop_reg;

    logic             hit;
    logic [BIN_W-1:0] cur_bin;
    det_state_t       eval_state;
    logic             close;
    det_rec_t         close_rec;
    logic             push_req;
    logic             pop;
    logic             accept;
    det_rec_t         head_rec;

    assign hit        = (vid_in >= thr);
    // A trig cycle is always bin 0 of a fresh sweep, whatever came before.
    assign cur_bin    = trig ? '0 : bin_reg;
    assign eval_state = trig ? SEARCH : state_reg;

    // Run tracking: at most one run closes per cycle (old run on trig, a miss
    // in RUN, or the last bin of the sweep), so a single close port suffices.
    always_comb begin
        state_next = state_reg;
        bin_next   = bin_reg;
        start_next = start_reg;
        len_next   = len_reg;
        peak_next  = peak_reg;
        close      = 1'b0;
        close_rec  = '0;

        if (trig && state_reg == RUN) begin
            close           = 1'b1;
            close_rec.range = start_reg;
            close_rec.len   = len_reg;
            close_rec.peak  = peak_reg;
        end

        if (trig || state_reg != IDLE) begin
            bin_next = cur_bin + 1'b1;
            case (eval_state)
                SEARCH: begin
                    state_next = SEARCH;
                    if (hit) begin
                        start_next = cur_bin;
                        len_next   = {{(LEN_W-1){1'b0}}, 1'b1};
                        peak_next  = vid_in;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (hit) begin
                        len_next  = sat_inc(len_reg);
                        peak_next = (vid_in > peak_reg) ? vid_in : peak_reg;
                    end else begin
                        close           = 1'b1;
                        close_rec.range = start_reg;
                        close_rec.len   = len_reg;
                        close_rec.peak  = peak_reg;
                        state_next      = SEARCH;
                    end
                end
                default: state_next = IDLE;
            endcase

            // Last bin: the run including this sample is closed and the
            // sweep ends until the next trig.
            if (cur_bin == BIN_W'(MAX_BIN)) begin
                if (state_next == RUN) begin
                    close           = 1'b1;
                    close_rec.range = start_next;
                    close_rec.len   = len_next;
                    close_rec.peak  = peak_next;
                end
                state_next = IDLE;
            end
        end
    end

    assign push_req = close && (close_rec.len >= LEN_W'(MIN_LEN));
    assign pop      = det_valid && det_ready;

    // Detector state, bin counter, open-run registers and the drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            start_reg <= '0;
            len_reg   <= '0;
            peak_reg  <= '0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            bin_reg   <= bin_next;
            start_reg <= start_next;
            len_reg   <= len_next;
            peak_reg  <= peak_next;
            drop_reg  <= push_req && !accept;
        end
    end

`ifdef DET_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    det_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_det_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .push_rec (close_rec),
        .pop      (pop),
        .head_rec (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign accept    = !fifo_full || pop;
    assign det_valid = !fifo_empty;
`else
    logic     out_valid_reg;
    det_rec_t out_rec_reg;

    assign accept    = !out_valid_reg || pop;
    assign det_valid = out_valid_reg;
    assign head_rec  = out_rec_reg;

    // Single-entry output holding register; a pop frees it for a same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_rec_reg   <= '0;
        end else begin
            if (push_req && accept) begin
                out_rec_reg   <= close_rec;
                out_valid_reg <= 1'b1;
            end else if (pop) begin
                out_valid_reg <= 1'b0;
            end
        end
    end
`endif

    assign det_range = head_rec.range;
    assign det_len   = head_rec.len;
    assign det_peak  = head_rec.peak;
    assign det_drop  = drop_reg;

endmodule

// File: tb/tb_stc_detector.sv
// Scoreboard bench for stc_detector (MAX_BIN=63, MIN_LEN=3, FIFO_DEPTH=4).
// Expected records are queued before each sweep; a negedge monitor pops and
// compares on every handshake, counts det_drop pulses and checks that a
// stalled head record holds still. Works with or without DET_FIFO_EN.
module tb_stc_detector;

    localparam int MIN_LEN    = 3;
    localparam int MAX_BIN    = 63;
    localparam int FIFO_DEPTH = 4;
`ifdef DET_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        int range;
        int len;
        int peak;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic [11:0] vid_in = '0;
    logic [11:0] thr = '0;
    logic        det_valid;
    logic        det_ready = 1'b0;
    logic [11:0] det_range;
    logic [11:0] det_len;
    logic [11:0] det_peak;
    logic        det_drop;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   drop_seen = 0;
    int   exp_drops = 0;
    int   vids[0:127];
    int   c0;
    logic        hold_prev = 1'b0;
    logic [35:0] prev_out = '0;

    stc_detector #(
        .MIN_LEN    (MIN_LEN),
        .MAX_BIN    (MAX_BIN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .vid_in    (vid_in),
        .thr       (thr),
        .det_valid (det_valid),
        .det_ready (det_ready),
        .det_range (det_range),
        .det_len   (det_len),
        .det_peak  (det_peak),
        .det_drop  (det_drop)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: drop pulses, stall stability and scoreboard compare.
    always @(negedge clk) begin
        if (det_drop) begin
            drop_seen++;
            $display("cyc %0d: det_drop pulse", cyc);
        end
        if (hold_prev && !rst) begin
            chk("stalled valid held", int'(det_valid), 1);
            chk("stalled record held", int'({det_range, det_len, det_peak} == prev_out), 1);
        end
        hold_prev = det_valid && !det_ready && !rst;
        prev_out  = {det_range, det_len, det_peak};
        if (det_valid && det_ready) begin
            $display("cyc %0d: record range=%0d len=%0d peak=%0d", cyc, det_range, det_len, det_peak);
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected record: got range=%0d len=%0d peak=%0d, required none",
                         det_range, det_len, det_peak);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("record range", int'(det_range), e.range);
                chk("record len", int'(det_len), e.len);
                chk("record peak", int'(det_peak), e.peak);
                if (e.cyc >= 0) chk("record cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input logic t, input int v);
        trig   = t;
        vid_in = 12'(v);
        @(posedge clk);
        #1;
        trig = 1'b0;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) drive(i == 0, vids[i]);
    endtask

    task automatic clear_vids();
        for (int i = 0; i < 128; i++) vids[i] = 0;
    endtask

    task automatic expect_rec(input int r, input int l, input int p, input int c);
        exp_t e;
        e.range = r;
        e.len   = l;
        e.peak  = p;
        e.cyc   = c;
        q.push_back(e);
    endtask

    task automatic phase_end(input string name);
        trig   = 1'b0;
        vid_in = '0;
        repeat (4) @(posedge clk);
        #1;
        chk({name, " pending records"}, q.size(), 0);
        chk({name, " drop count"}, drop_seen, exp_drops);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset det_valid", int'(det_valid), 0);
        chk("reset det_range", int'(det_range), 0);
        chk("reset det_len", int'(det_len), 0);
        chk("reset det_peak", int'(det_peak), 0);
        chk("reset det_drop", int'(det_drop), 0);
        rst       = 1'b0;
        thr       = 12'd100;
        det_ready = 1'b1;
        drive(1'b0, 0);

        // Run report: bins 10..14 above threshold, closed by the miss at bin 15
        clear_vids();
        vids[10] = 200; vids[11] = 300; vids[12] = 250; vids[13] = 150; vids[14] = 120;
        c0 = cyc;
        expect_rec(10, 5, 300, c0 + 1 + 15);
        sweep(64);
        phase_end("run report");

        // Short run of two samples is discarded silently
        clear_vids();
        vids[20] = 200; vids[21] = 200;
        sweep(64);
        phase_end("short run");

        // Sweep end: run reaching bin 63 closes there, later samples ignored
        clear_vids();
        vids[60] = 150; vids[61] = 400; vids[62] = 350; vids[63] = 200;
        for (int i = 64; i < 70; i++) vids[i] = 900;
        c0 = cyc;
        expect_rec(60, 4, 400, c0 + 1 + 63);
        sweep(70);
        phase_end("sweep end");

        // Trig mid-run: old run {5,4} closes on trig, new run starts at bin 0
        clear_vids();
        vids[5] = 200; vids[6] = 210; vids[7] = 230; vids[8] = 220;
        c0 = cyc;
        expect_rec(5, 4, 230, c0 + 1 + 9);
        expect_rec(0, 3, 270, c0 + 1 + 12);
        sweep(9);
        clear_vids();
        vids[0] = 250; vids[1] = 270; vids[2] = 260;
        sweep(64);
        phase_end("trig mid-run");

        // Backpressure: six 3-sample runs with det_ready low, then drain
        det_ready = 1'b0;
        clear_vids();
        for (int k = 0; k < 6; k++) begin
            vids[1 + 4*k] = 200 + 20*k;
            vids[2 + 4*k] = 250 + 20*k;
            vids[3 + 4*k] = 220 + 20*k;
        end
        c0 = cyc;
        for (int k = 0; k < CAP; k++) expect_rec(1 + 4*k, 3, 250 + 20*k, c0 + 64 + k);
        exp_drops += 6 - CAP;
        sweep(64);
        det_ready = 1'b1;
        repeat (CAP + 2) @(posedge clk);
        #1;
        phase_end("backpressure");

        // Reset during RUN with records buffered
        det_ready = 1'b0;
        clear_vids();
        for (int i = 1; i < 4; i++) vids[i] = 300;
        for (int i = 5; i < 8; i++) vids[i] = 300;
        for (int i = 9; i < 21; i++) vids[i] = 300;
        if (CAP < 2) exp_drops += 1;
        sweep(11);
        chk("pre-reset det_valid", int'(det_valid), 1);
        rst = 1'b1;
        #1;
        chk("async reset det_valid", int'(det_valid), 0);
        chk("async reset det_range", int'(det_range), 0);
        chk("async reset det_len", int'(det_len), 0);
        chk("async reset det_peak", int'(det_peak), 0);
        chk("async reset det_drop", int'(det_drop), 0);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        det_ready = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b0, 300);
        phase_end("reset mid-run");

        // thr=0: every sample is a hit, one record spanning the whole sweep
        thr = 12'd0;
        clear_vids();
        for (int i = 0; i < 64; i++) vids[i] = i * 7 + 3;
        c0 = cyc;
        expect_rec(0, MAX_BIN + 1, 63 * 7 + 3, c0 + 1 + 63);
        sweep(64);
        phase_end("thr zero");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/stc_detector.md
# stc_detector

Threshold detector that sits directly downstream of the sensitivity-time-control stage on the 50 MHz radar video path. Per sweep, it compares each STC-corrected 12-bit sample against a programmable threshold and groups consecutive above-threshold samples into runs. Each qualifying run is emitted as a detection record (start range bin, length, peak amplitude) over a valid/ready handshake to the plot-extraction logic.

## Interface
Parameters:
- MIN_LEN, 3: minimum run length (samples) for a run to be reported; legal range 1..4095.
- MAX_BIN, 4095: last range bin of a sweep; legal range 1..4095.
- FIFO_DEPTH, 4: record buffer depth; power of two, ≥2; used only with DET_FIFO_EN.

Ports:
- clk  in  1  system clock, 50 MHz, one video sample per cycle.
- rst  in  1  reset; asynchronous, active-high.
- trig  in  1  sweep start; single-cycle pulse synchronous to clk, and that cycle's sample is bin 0.
- vid_in  in  12  STC-corrected video sample, unsigned.
- thr  in  12  detection threshold, unsigned; sampled every cycle.
- det_valid  out  1  record available.
- det_ready  in  1  consumer accepts the record when det_valid && det_ready.
- det_range  out  12  bin of first sample in the run.
- det_len  out  12  run length in samples, saturating at 4095.
- det_peak  out  12  maximum vid_in within the run.
- det_drop  out  1  one-cycle pulse when a qualifying record is discarded because the buffer is full.

## Operation
- A sample is a hit when vid_in >= thr (unsigned compare).
- Bin counter:
  - Loads 0 on trig.
  - Otherwise increments by 1 per cycle while a sweep is active.
  - Bin MAX_BIN is the last evaluated sample.
- State machine:
  - IDLE: no sweep active; samples are ignored. On trig, evaluate the sample as in SEARCH at bin 0.
  - SEARCH: on a hit, set start=bin, len=1, peak=vid_in, and go to RUN.
  - RUN:
    - On a hit: len=len+1 (saturating at 4095), peak=max(peak, vid_in).
    - On a miss: close the run and go to SEARCH.
  - End of sweep: after the sample at bin MAX_BIN is evaluated, any open run is closed, including that sample if it was a hit. The state then goes to IDLE.
  - trig in SEARCH or RUN: the open run is closed using samples before the trig cycle. A new sweep then starts, and the trig-cycle sample is evaluated as bin 0. A close and a new run start may therefore happen in the same cycle.
- Closing a run: push a record {start, len, peak} only if len >= MIN_LEN. Shorter runs are discarded silently; det_drop is not asserted for them.
- Push while the buffer is full: the record is discarded and det_drop pulses. If a pop happens in the same cycle, the push is accepted.
- Reset:
  - State IDLE, bin 0, run registers 0, buffer empty.
  - det_valid=0, det_range=0, det_len=0, det_peak=0, det_drop=0.
  - Reset mid-sweep discards the open run and all buffered records.

## Timing
- The record for a run closed by the sample at cycle t is visible at the outputs in cycle t+1, provided the buffer was empty.
- det_drop is asserted in cycle t+1 for a discard decided at cycle t.
- The outputs of the head record hold stable while det_valid && !det_ready.
- After a handshake in cycle k, the next record (if any) is presented in cycle k+1. Full throughput is one record per cycle.
- det_valid depends only on registered state; there is no combinational path from det_ready to det_valid.

## Configuration
- DET_FIFO_EN defined: records are buffered in a FIFO of FIFO_DEPTH entries, with first-word fall-through to the outputs.
- DET_FIFO_EN undefined: a single output register is used.
  - A push is accepted if the register is empty or is popped in the same cycle.
  - Otherwise the record is dropped and det_drop pulses.
  - FIFO_DEPTH is ignored.

## Structure
- Shared package stc_pkg contains:
  - VID_W=12 and BIN_W=12.
  - The det_rec_t packed struct {range, len, peak}.
  - The detector state enum {IDLE, SEARCH, RUN}.
- One sub-module, det_fifo: a synchronous FIFO of det_rec_t with first-word fall-through, full/empty flags and simultaneous push/pop. It is instantiated only under DET_FIFO_EN.

## Test plan
- Run report: thr=100, trig, then bins 10..14 = 200,300,250,150,120, others 0, det_ready=1 → one record {range=10, len=5, peak=300} at cycle after bin 15.
- Short run: MIN_LEN=3, hits at bins 20..21 only → no det_valid, no det_drop.
- Sweep end: MAX_BIN=63, hits from bin 60 to 63 and beyond → record {60, 4, peak}. Samples after bin 63 are ignored until the next trig.
- Trig mid-run: hit run from bin 5, trig at bin 9 with hit on trig sample → record {5, 4, …}, plus a new run starting at range 0.
- Backpressure: det_ready=0 with FIFO_DEPTH=4, six 3-sample runs → first four held in order, two det_drop pulses. Then set det_ready=1 → four records drain on consecutive cycles.
- Reset mid-run and boundary: assert rst during RUN with two records buffered → all outputs 0 immediately, no record after release. thr=0 → every sample is a hit, giving a single record {0, MAX_BIN+1, max}.
